acia_rx: RTL and testbench
==========================

Name: acia_rx

Overview:
- 6551-compatible ACIA receiver: deserialises RXD using the 16x baud clock BCLK from the baud-rate generator, checks parity and stop bit, and presents the character to the CPU-side register file.
- Clocked by the system clock CLK.
- BCLK is treated as data: synchronised, then edge-detected into a one-cycle 16x tick.
- Sits between the baud-rate generator and the ACIA status/data register decode.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on BCLK and RXD (minimum 2).

Ports:
- CLK  input  1  system clock; frequency must be at least 4x BCLK.
- RESET  input  1  reset, asynchronous, active-low.
- BCLK  input  1  16x baud clock from the baud-rate generator (asynchronous to CLK).
- RXD  input  1  serial receive line, idle high.
- WL  input  2  word length: 00=8, 01=7, 10=6, 11=5 bits.
- PAR_EN  input  1  parity bit present and checked.
- PAR_MODE  input  2  parity type: 00=odd, 01=even, 10=mark (1), 11=space (0).
- RD_STB  input  1  one-cycle pulse on CPU read of the receive data register.
- RX_DATA  output  8  received character, LSB first on wire; unused upper bits 0.
- RDRF  output  1  receive data register full.
- PE  output  1  parity error of last loaded character.
- FE  output  1  framing error of last loaded character.
- OVR  output  1  overrun: a character completed while RDRF=1.

Behaviour:
- Reset: RX_DATA=0, RDRF=0, PE=0, FE=0, OVR=0, state=IDLE, armed=0, tick counter=0, bit counter=0.
- Synchronisers reset to 1 for RXD and 0 for BCLK.
- tick: one-CLK pulse on each synchronised BCLK rising edge. All bit timing advances only on tick.
- Sample point: the synchronised RXD value at the tick where the tick counter hits the sample point (single sample, or majority per the optional feature).
- armed: set when a sampled RXD in IDLE is 1. Cleared on leaving IDLE. Prevents a held break from retriggering.
- IDLE: on tick with armed=1 and RXD=0:
  - go to START, counter=0;
  - latch WL, PAR_EN and PAR_MODE for the whole frame (mid-frame config changes are ignored).
- START: on tick 7 (the 8th tick after detect), sample the start bit.
  - 0: go to DATA, counter=0, bit index=0.
  - 1: false start, return to IDLE; no flag changes.
- DATA: sample on every 16th tick (counter==15) and shift into bit[index].
  - After the last bit (index = 8/7/6/5 minus 1), go to PARITY if PAR_EN, else STOP.
- PARITY: sample at counter==15. Expected value:
  - odd: XOR of data bits XOR 1;
  - even: XOR of data bits;
  - mark: 1;
  - space: 0.
  - Mismatch is held as pending PE.
- STOP: sample at counter==15.
  - FE = (sample==0). Only the first stop bit is checked.
  - Load is performed on the same CLK as the sample, then state returns to IDLE with armed=0.
- Load:
  - RDRF=0 before load: RX_DATA<=character, PE/FE<=pending values, RDRF<=1.
  - RDRF=1 before load: OVR<=1; RX_DATA, PE and FE are unchanged; the new character is discarded.
- RD_STB: clears RDRF and OVR the cycle after.
- RD_STB in the same cycle as a load: load takes priority as if RDRF=0. RDRF stays 1, data is replaced, OVR is cleared.
- Break (RXD held 0): one load with RX_DATA=0x00 and FE=1; no further loads until RXD is sampled 1.
- RESET asserted mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
- Macro: ACIA_RX_MAJORITY_EN.
- Defined: each sample point uses a 2-of-3 majority of RXD at counter positions 7, 8, 9 (START) or 14, 15, 0-of-next-window-aligned 15±1 (DATA, PARITY, STOP). Decision is made at the last of the three ticks. A START vote of 1 is a false start.
- Undefined: single sample at the points in Behaviour; no vote registers are synthesised.

Test Plan:
- 8N1, WL=00, PAR_EN=0, send 0xA5 with 16 ticks/bit -> RX_DATA=0xA5, RDRF=1, PE=0, FE=0, OVR=0 after the stop sample.
- 7E1, WL=01, PAR_MODE=01, send 0x41 with wrong parity bit=1 -> RX_DATA=0x41, PE=1; repeat with parity=0 -> PE=0.
- 8N1 send 0x55 with stop bit=0, then hold RXD low for 3 frames -> exactly one load: RX_DATA=0x00... first 0x55/FE=1; no further RDRF re-set until RXD returns high and a new frame arrives.
- Send 0x11 and 0x22 without RD_STB -> RX_DATA=0x11, OVR=1; RD_STB -> RDRF=0, OVR=0.
- 4-tick low glitch on idle RXD -> START aborts at tick 7, RDRF stays 0, the next valid 0x3C is received correctly.
- RESET pulsed during DATA bit 3 of 0xFF -> all outputs 0; the following 5-bit frame (WL=11) of 0x1F gives RX_DATA=0x1F.

Source files
------------

// File: rtl/acia_rx_if.sv
// ---------------------------------------------------------------------------
// acia_rx_if
// Signal bundle between the ACIA receiver and its surroundings: the
// baud-rate generator and serial line on one side, the CPU-side status/data
// register decode on the other.
//
//   BCLK      16x baud clock (asynchronous, treated as data)
//   RXD       serial receive line, idle high
//   WL        word length: 00=8, 01=7, 10=6, 11=5 bits
//   PAR_EN    parity bit present and checked
//   PAR_MODE  00=odd, 01=even, 10=mark, 11=space
//   RD_STB    one-cycle pulse on CPU read of the receive data register
//   RX_DATA   received character (unused upper bits 0)
//   RDRF      receive data register full
//   PE / FE   parity / framing error of the last loaded character
//   OVR       overrun
//
// master: the side driving line, baud clock and configuration.
// slave : the receiver itself.
// ---------------------------------------------------------------------------
interface acia_rx_if;
  logic       BCLK;
  logic       RXD;
  logic [1:0] WL;
  logic       PAR_EN;
  logic [1:0] PAR_MODE;
  logic       RD_STB;
  logic [7:0] RX_DATA;
  logic       RDRF;
  logic       PE;
  logic       FE;
  logic       OVR;

  modport master (
    output BCLK, RXD, WL, PAR_EN, PAR_MODE, RD_STB,
    input  RX_DATA, RDRF, PE, FE, OVR
  );

  modport slave (
    input  BCLK, RXD, WL, PAR_EN, PAR_MODE, RD_STB,
    output RX_DATA, RDRF, PE, FE, OVR
  );
endinterface

// File: rtl/acia_rx.sv
// ---------------------------------------------------------------------------
// acia_rx
// 6551-compatible ACIA receiver. BCLK (16x baud) and RXD are synchronised
// into the CLK domain; each BCLK rising edge becomes a one-cycle tick that
// drives all bit timing. A frame is start / 5-8 data bits (LSB first) /
// optional parity / stop. The finished character is loaded into RX_DATA
// with PE/FE, or flagged as overrun if RDRF is still set.
//
// Ports:
//   CLK    system clock (at least 4x BCLK)
//   RESET  asynchronous, active-low reset
//   bus    acia_rx_if.slave (BCLK, RXD, WL, PAR_EN, PAR_MODE, RD_STB in;
//          RX_DATA, RDRF, PE, FE, OVR out, all registered)
//
// Parameter: SYNC_STAGES - synchroniser depth for BCLK and RXD (>= 2).
//
// Optional build macro ACIA_RX_MAJORITY_EN: every sample point becomes a
// 2-of-3 vote over three consecutive ticks, decided on the last one.
// ---------------------------------------------------------------------------
module acia_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic     CLK,
  input  logic     RESET,
  acia_rx_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Decision points. The tick counter free-runs (wrapping 15->0) through a
  // frame, so only the START exit needs an explicit reload to keep every
  // later decision centred in its bit cell.
`ifdef ACIA_RX_MAJORITY_EN
  localparam logic [3:0] START_DEC  = 4'd9;
  localparam logic [3:0] START_EXIT = 4'd2;
  localparam logic [3:0] BIT_DEC    = 4'd0;
`else
  localparam logic [3:0] START_DEC  = 4'd7;
  localparam logic [3:0] START_EXIT = 4'd0;
  localparam logic [3:0] BIT_DEC    = 4'd15;
`endif

  function automatic logic exp_parity(input logic [7:0] data, input logic [1:0] mode);
    logic p;
    case (mode)
      2'b00:   p = ~(^data);
      2'b01:   p = ^data;
      2'b10:   p = 1'b1;
      2'b11:   p = 1'b0;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_rxd_sync;
  logic                   r_bclk_prev;
  logic                   w_tick;
  logic                   w_rxd;
  logic                   w_sample;
  logic                   w_in_bit;
  logic                   w_dec_start;
  logic                   w_dec_bit;
  logic                   w_load;
  logic [2:0]             w_last_idx;

  logic [2:0] r_state;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_idx;
  logic       r_armed;
  logic [1:0] r_wl;
  logic       r_par_en;
  logic [1:0] r_par_mode;
  logic [7:0] r_shift;
  logic       r_pe_pend;

  logic [7:0] r_rx_data;
  logic       r_rdrf;
  logic       r_pe;
  logic       r_fe;
  logic       r_ovr;

  // Synchronise BCLK and RXD; RXD resets to the idle (mark) level.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_bclk_sync <= '0;
      r_rxd_sync  <= '1;
      r_bclk_prev <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], bus.BCLK};
      r_rxd_sync  <= {r_rxd_sync[SYNC_STAGES-2:0], bus.RXD};
      r_bclk_prev <= r_bclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_tick      = r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_prev;
  assign w_rxd       = r_rxd_sync[SYNC_STAGES-1];
  assign w_last_idx  = 3'd7 - {1'b0, r_wl};
  assign w_in_bit    = (r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_dec_start = w_tick && (r_state == S_START) && (r_tick_cnt == START_DEC);
  assign w_dec_bit   = w_tick && w_in_bit && (r_tick_cnt == BIT_DEC);
  assign w_load      = w_dec_bit && (r_state == S_STOP);

`ifdef ACIA_RX_MAJORITY_EN
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0] r_vote;
  logic       w_vote_en;

  assign w_vote_en = w_tick &&
                     (((r_state == S_START) && ((r_tick_cnt == 4'd7) || (r_tick_cnt == 4'd8))) ||
                      (w_in_bit && ((r_tick_cnt == 4'd14) || (r_tick_cnt == 4'd15))));

  // Hold the first two votes of each sample window.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_vote <= 2'b11;
    end else if (w_vote_en) begin
      r_vote <= {r_vote[0], w_rxd};
    end else begin
      r_vote <= r_vote;
    end
  end

  assign w_sample = majority3(r_vote[1], r_vote[0], w_rxd);
`else
  assign w_sample = w_rxd;
`endif

  // Frame FSM: start detect, bit timing, deserialisation, parity check.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_armed    <= 1'b0;
      r_wl       <= 2'b00;
      r_par_en   <= 1'b0;
      r_par_mode <= 2'b00;
      r_shift    <= 8'h00;
      r_pe_pend  <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          // armed needs a sampled mark first, so a held break cannot retrigger
          if (w_rxd) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state    <= S_START;
            r_tick_cnt <= 4'd0;
            r_armed    <= 1'b0;
            r_wl       <= bus.WL;
            r_par_en   <= bus.PAR_EN;
            r_par_mode <= bus.PAR_MODE;
            r_shift    <= 8'h00;
            r_pe_pend  <= 1'b0;
          end
        end
        S_START: begin
          if (w_dec_start) begin
            if (!w_sample) begin
              r_state    <= S_DATA;
              r_tick_cnt <= START_EXIT;
              r_bit_idx  <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
          end
        end
        S_DATA: begin
          r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_dec_bit) begin
            r_shift[r_bit_idx] <= w_sample;
            if (r_bit_idx == w_last_idx) begin
              r_state <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        S_PARITY: begin
          r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_dec_bit) begin
            r_pe_pend <= (w_sample != exp_parity(r_shift, r_par_mode));
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_dec_bit) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  // CPU-visible register: load on stop sample, clear on read; a load in
  // the same cycle as a read behaves as if the register were empty.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rx_data <= 8'h00;
      r_rdrf    <= 1'b0;
      r_pe      <= 1'b0;
      r_fe      <= 1'b0;
      r_ovr     <= 1'b0;
    end else if (w_load) begin
      if (!r_rdrf || bus.RD_STB) begin
        r_rx_data <= r_shift;
        r_pe      <= r_pe_pend;
        r_fe      <= ~w_sample;
        r_rdrf    <= 1'b1;
        r_ovr     <= 1'b0;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (bus.RD_STB) begin
      r_rdrf <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_rdrf <= r_rdrf;
    end
  end

  assign bus.RX_DATA = r_rx_data;
  assign bus.RDRF    = r_rdrf;
  assign bus.PE      = r_pe;
  assign bus.FE      = r_fe;
  assign bus.OVR     = r_ovr;

endmodule

// File: tb/tb_acia_rx.sv
// ---------------------------------------------------------------------------
// tb_acia_rx
// Directed bench for acia_rx: frames are bit-banged on RXD, one bit per 16
// BCLK periods, changing on BCLK falling edges. Expected values are written
// out by hand next to each vector.
// ---------------------------------------------------------------------------
module tb_acia_rx;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  acia_rx_if bus ();

  acia_rx #(.SYNC_STAGES(2)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bus.BCLK = 1'b0;
    forever #40 bus.BCLK = ~bus.BCLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.RXD = b;
    repeat (16) @(negedge bus.BCLK);
  endtask

  // RXD is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] d, input int nbits,
                            input logic has_par, input logic par, input logic stop);
    @(negedge bus.BCLK);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (has_par) send_bit(par);
    send_bit(stop);
  endtask

  task automatic cpu_read();
    @(negedge clk);
    bus.RD_STB = 1'b1;
    @(negedge clk);
    bus.RD_STB = 1'b0;
    @(negedge clk);
  endtask

  task automatic par_case(input string tag, input logic [1:0] wl, input logic [1:0] mode,
                          input logic [7:0] d, input logic par, input logic exp_pe);
    bus.WL       = wl;
    bus.PAR_EN   = 1'b1;
    bus.PAR_MODE = mode;
    send_frame(d, 8 - int'(wl), 1'b1, par, 1'b1);
    check_eq({tag, "_data"}, bus.RX_DATA, d);
    check_eq({tag, "_pe"}, {7'd0, bus.PE}, {7'd0, exp_pe});
    cpu_read();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.RXD    = 1'b1;
    bus.WL     = 2'b00;
    bus.PAR_EN = 1'b0;
    bus.PAR_MODE = 2'b00;
    bus.RD_STB = 1'b0;

    // Reset values
    repeat (5) @(negedge clk);
    check_eq("rst_data", bus.RX_DATA, 8'h00);
    check_eq("rst_flags", {3'd0, bus.RDRF, bus.PE, bus.FE, bus.OVR, 1'b0}, 8'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge bus.BCLK);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check_eq("a5_data", bus.RX_DATA, 8'hA5);
    check_eq("a5_rdrf", {7'd0, bus.RDRF}, 8'h01);
    check_eq("a5_pe", {7'd0, bus.PE}, 8'h00);
    check_eq("a5_fe", {7'd0, bus.FE}, 8'h00);
    check_eq("a5_ovr", {7'd0, bus.OVR}, 8'h00);
    cpu_read();
    check_eq("a5_read_rdrf", {7'd0, bus.RDRF}, 8'h00);

    // Parity vectors
    par_case("7e1_bad",   2'b01, 2'b01, 8'h41, 1'b1, 1'b1);
    par_case("7e1_good",  2'b01, 2'b01, 8'h41, 1'b0, 1'b0);
    par_case("8o1_bad",   2'b00, 2'b00, 8'h07, 1'b1, 1'b1);
    par_case("5o1_good",  2'b11, 2'b00, 8'h15, 1'b0, 1'b0);
    par_case("8m1_bad",   2'b00, 2'b10, 8'hC3, 1'b0, 1'b1);
    par_case("6s1_good",  2'b10, 2'b11, 8'h2A, 1'b0, 1'b0);
    bus.WL     = 2'b00;
    bus.PAR_EN = 1'b0;

    // Short low glitch: start aborted, next frame fine
    @(negedge bus.BCLK);
    bus.RXD = 1'b0;
    repeat (4) @(negedge bus.BCLK);
    bus.RXD = 1'b1;
    repeat (32) @(negedge bus.BCLK);
    check_eq("glitch_rdrf", {7'd0, bus.RDRF}, 8'h00);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    check_eq("glitch_next_data", bus.RX_DATA, 8'h3C);
    check_eq("glitch_next_rdrf", {7'd0, bus.RDRF}, 8'h01);
    cpu_read();

    // Bad stop bit then line held low for 3 frames: one load only
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0);
    repeat (480) @(negedge bus.BCLK);
    check_eq("brk55_data", bus.RX_DATA, 8'h55);
    check_eq("brk55_fe", {7'd0, bus.FE}, 8'h01);
    check_eq("brk55_ovr", {7'd0, bus.OVR}, 8'h00);
    cpu_read();
    repeat (480) @(negedge bus.BCLK);
    check_eq("brk_hold_rdrf", {7'd0, bus.RDRF}, 8'h00);
    bus.RXD = 1'b1;
    repeat (32) @(negedge bus.BCLK);
    check_eq("brk_rel_rdrf", {7'd0, bus.RDRF}, 8'h00);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1);
    check_eq("brk_next_data", bus.RX_DATA, 8'h0F);
    check_eq("brk_next_fe", {7'd0, bus.FE}, 8'h00);
    cpu_read();

    // Break from idle: one 0x00 character with FE
    @(negedge bus.BCLK);
    bus.RXD = 1'b0;
    repeat (480) @(negedge bus.BCLK);
    check_eq("break_data", bus.RX_DATA, 8'h00);
    check_eq("break_fe", {7'd0, bus.FE}, 8'h01);
    check_eq("break_rdrf", {7'd0, bus.RDRF}, 8'h01);
    check_eq("break_ovr", {7'd0, bus.OVR}, 8'h00);
    cpu_read();
    bus.RXD = 1'b1;
    repeat (32) @(negedge bus.BCLK);

    // Overrun
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    check_eq("ovr_data", bus.RX_DATA, 8'h11);
    check_eq("ovr_flag", {7'd0, bus.OVR}, 8'h01);
    check_eq("ovr_rdrf", {7'd0, bus.RDRF}, 8'h01);
    cpu_read();
    check_eq("ovr_read_rdrf", {7'd0, bus.RDRF}, 8'h00);
    check_eq("ovr_read_ovr", {7'd0, bus.OVR}, 8'h00);

    // Reset during data bit 3 of 0xFF (RDRF held set by a prior 0x33)
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
    check_eq("pre_rst_data", bus.RX_DATA, 8'h33);
    @(negedge bus.BCLK);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (8) @(negedge bus.BCLK);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midrst_data", bus.RX_DATA, 8'h00);
    check_eq("midrst_flags", {3'd0, bus.RDRF, bus.PE, bus.FE, bus.OVR, 1'b0}, 8'h00);
    rst_n = 1'b1;
    repeat (40) @(negedge bus.BCLK);
    check_eq("postrst_rdrf", {7'd0, bus.RDRF}, 8'h00);
    bus.WL = 2'b11;
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1);
    check_eq("wl5_data", bus.RX_DATA, 8'h1F);
    check_eq("wl5_rdrf", {7'd0, bus.RDRF}, 8'h01);
    check_eq("wl5_fe", {7'd0, bus.FE}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
